dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the load/store port of the 32-bit ARM-like CPU. It is the memory end of the CPU's data-access handshake.
- Accepts one read or write request at a time and inserts a programmable number of wait states. Returns one response pulse per request.
- Supports word and byte accesses and flags misaligned or out-of-range addresses.
- Used in the top-level system and by CPU benches to exercise stalls.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 32, data width in bits; fixed at 32 for byte-lane logic.
- DEPTH_WORDS, 64, number of 32-bit words stored. Must be a power of two, at least 4.
- WAIT_CYCLES, 2, wait states between acceptance and response. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; block is held in reset while reset==0.
- req_valid  in  1  CPU presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (STRB/LDRB), 0 = word access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data; for byte stores, bits [7:0] are used.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range; valid only with rsp_valid.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0.
- Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at edge T: latch write, byte, addr, wdata and the error flag.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - req_ready=0; counter counts 0..WAIT_CYCLES-1.
  - Leave for RESP when the count reaches WAIT_CYCLES-1.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in this cycle.
  - Latency: rsp_valid is high in cycle T+1+WAIT_CYCLES.
  - Back-to-back requests are therefore spaced at least WAIT_CYCLES+2 cycles apart.
- Memory access timing:
  - The write commits on the edge that enters RESP.
  - Read data is sampled on that same edge and registered into rsp_rdata.
  - A load issued after a store to the same address returns the new data.
- Word index is addr[ADDR_W-1:2]. Storage is little-endian; byte lane = addr[1:0].
- Error conditions, checked on the latched request:
  - misaligned = word access with addr[1:0] != 0.
  - out of range = word index >= DEPTH_WORDS.
  - Either condition sets rsp_err=1 and rsp_rdata=0, and memory is left unmodified.
- Byte store: only lane addr[1:0] is written, with wdata[7:0]; the other three bytes are preserved.
- Byte load: rsp_rdata = {24'b0, selected byte}, zero-extended.
- Word store: writes all four bytes.
- Word load: returns the full word.
- req_* inputs are ignored outside IDLE. Input changes during WAIT or RESP have no effect.
- rsp_rdata and rsp_err hold their values after the RESP cycle until the next RESP, and are qualified only by rsp_valid.
- Reset mid-operation: reset asserted in WAIT drops the request. No write occurs and no response is issued; outputs return to their reset values immediately.
- Simultaneous events: a request arriving in the RESP cycle is not accepted (req_ready=0) and must be held by the CPU until IDLE.

Decomposition:
- dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - localparams for byte-lane width (8) and lane count (4);
  - a function to compute the error flag from addr, byte and DEPTH_WORDS.
- Sub-module dmem_array: DEPTH_WORDS x 32 storage with a 4-bit byte-enable write and synchronous read. The FSM, counter, lane steering and error logic stay in dmem_responder.

Test Plan:
- Reset then idle → req_ready=1, rsp_valid=0, rsp_rdata=0.
- Word store 0xDEADBEEF at 0x10, then word load at 0x10, WAIT_CYCLES=2 → store rsp_valid at T+3 with rsp_err=0; load returns 0xDEADBEEF at its T+3.
- Word 0x11223344 at 0x20; byte store 0xAA at 0x22; word load at 0x20 → 0x11AA3344. Byte load at 0x23 → 0x00000011.
- Word load at 0x06 (misaligned), and word store at DEPTH_WORDS*4 (0x100) → rsp_err=1, rsp_rdata=0; a following load at 0xFC shows the prior contents unchanged.
- WAIT_CYCLES=0 build: request at T → rsp_valid at T+1. Hold req_valid high continuously → requests accepted at most every 2 cycles and req_ready=0 in each RESP cycle.
- Store 0x55 to 0x08; pull reset low during WAIT, then release → no rsp_valid pulse; a word load at 0x08 returns the pre-store value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, byte-lane constants and address check for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam int LANE_W = 8;
  localparam int LANES = 4;
  function automatic logic addr_err(input logic [63:0] addr, input logic is_byte, input int depth);
    return (!is_byte && addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with per-byte write enables and a registered read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic [LANES-1:0]        we_i,
  input  logic                    re_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [LANES*LANE_W-1:0] wdata_i,
  output logic [LANES*LANE_W-1:0] rdata_o
);
  logic [LANES*LANE_W-1:0] mem_q [DEPTH];
  // Lane writes and the read share one edge; a read on that edge sees the old word
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++)
      if (we_i[i]) mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
    if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  state_e state_q;
  logic [3:0] cnt_q;
  logic write_q, byte_q, err_q;
  logic [AW+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic req_ready_q, rsp_valid_q, rsp_err_q, rsp_zero_q, rsp_byte_q;
  logic [1:0] rsp_lane_q;
  logic idle, cur_write, cur_byte, cur_err, go_resp;
  logic [AW+1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, arr_wdata, arr_rdata;
  logic [LANES-1:0] we;
  logic [LANE_W-1:0] rd_byte;
  // In IDLE the live request drives the array so a zero-wait build commits on the accept edge
  always_comb begin
    idle = state_q == IDLE;
    cur_write = idle ? req_write : write_q;
    cur_byte = idle ? req_byte : byte_q;
    cur_addr = idle ? req_addr[AW+1:0] : addr_q;
    cur_wdata = idle ? req_wdata : wdata_q;
    cur_err = idle ? addr_err(64'(req_addr), req_byte, DEPTH_WORDS) : err_q;
    go_resp = idle ? req_valid && WAIT_CYCLES == 0 : state_q == WAIT && cnt_q == LAST;
    we = go_resp && cur_write && !cur_err ? (cur_byte ? LANES'(1) << cur_addr[1:0] : '1) : '0;
    arr_wdata = cur_byte ? {LANES{cur_wdata[LANE_W-1:0]}} : cur_wdata;
  end
  // Response data is steered from the registered array word using lane info captured with it
  always_comb begin
    rd_byte = arr_rdata[{rsp_lane_q, 3'b000} +: LANE_W];
    rsp_rdata = rsp_zero_q ? '0 : rsp_byte_q ? DATA_W'(rd_byte) : arr_rdata;
  end
  dmem_array #(.DEPTH(DEPTH_WORDS)) u_array (
    .clk_i  (clk),
    .we_i   (we),
    .re_i   (go_resp),
    .addr_i (cur_addr[AW+1:2]),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );
  // Request FSM: latch in IDLE, count wait states, pulse the response for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      write_q <= 1'b0;
      byte_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_zero_q <= 1'b1;
      rsp_byte_q <= 1'b0;
      rsp_lane_q <= '0;
    end else begin
      rsp_valid_q <= go_resp;
      if (go_resp) begin
        rsp_err_q <= cur_err;
        rsp_zero_q <= cur_err | cur_write;
        rsp_byte_q <= cur_byte;
        rsp_lane_q <= cur_addr[1:0];
      end
      case (state_q)
        IDLE: if (req_valid) begin
          write_q <= req_write;
          byte_q <= req_byte;
          addr_q <= req_addr[AW+1:0];
          wdata_q <= req_wdata;
          err_q <= cur_err;
          req_ready_q <= 1'b0;
          state_q <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + 4'd1;
          if (cnt_q == LAST) state_q <= RESP;
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
endmodule
